// File: rtl/index_sort_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : index_sort_engine_pkg
// Description : Shared widths, FSM state encoding and the {value,index} entry.
// Revision    : 1.0 - initial release
// ============================================================================
package index_sort_engine_pkg;

    localparam int NETWORK_WIDTH = 16;
    localparam int INDEX_WIDTH   = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Index field is sized for the largest frame (256 entries).
    typedef struct packed {
        logic [NETWORK_WIDTH-1:0] value;
        logic [INDEX_WIDTH-1:0]   index;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/index_sort_engine_cmp_exchange.sv
`default_nettype none
// ============================================================================
// Module      : sort_cmp_exchange
// Description : One combinational compare-exchange cell of the sorting network.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_cmp_exchange
    import index_sort_engine_pkg::*;
(
    input  entry_t i_a,
    input  entry_t i_b,
    input  logic   i_desc,
    output entry_t o_a,
    output entry_t o_b
);

    logic w_swap;

    // Strict comparison only, so equal values never trade places.
    assign w_swap = i_desc ? (i_a.value < i_b.value) : (i_a.value > i_b.value);
    assign o_a    = w_swap ? i_b : i_a;
    assign o_b    = w_swap ? i_a : i_b;

endmodule
`default_nettype wire

// File: rtl/index_sort_engine.sv
`default_nettype none
// ============================================================================
// Module      : index_sort_engine
// Description : Frame loader, odd-even transposition sorter and top-K drain.
// Revision    : 1.0 - initial release
// ============================================================================
module index_sort_engine
    import index_sort_engine_pkg::*;
#(
    parameter int N_ENTRIES = 32,
    parameter int DATA_W    = NETWORK_WIDTH,
    parameter int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              desc_i,
    input  logic [IDX_W:0]    topk_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy
);

    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(N_ENTRIES - 1);
    localparam logic [IDX_W:0]   C_N    = (IDX_W+1)'(N_ENTRIES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_load_cnt;
    logic [IDX_W-1:0] r_phase;
    logic [IDX_W-1:0] r_rd_ptr;
    logic [IDX_W-1:0] r_k_last;
    logic             r_desc;
    logic [IDX_W-1:0] w_k_last;
    logic             w_in_fire;
    logic             w_out_fire;

    entry_t r_mem  [N_ENTRIES];
    entry_t w_even [N_ENTRIES];
    entry_t w_odd  [N_ENTRIES];

    assign w_in_fire  = in_valid  && (r_state == ST_LOAD);
    assign w_out_fire = out_ready && (r_state == ST_DRAIN);
    assign w_k_last   = ((topk_i == '0) || (topk_i > C_N)) ? C_LAST
                                                             : IDX_W'(topk_i - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_load_cnt == C_LAST)) w_state_nxt = ST_SORT;
            end
            ST_SORT: begin
                busy = 1'b1;
                if (r_phase == C_LAST) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && (r_rd_ptr == r_k_last)) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_cnt <= '0;
            r_phase    <= '0;
            r_rd_ptr   <= '0;
            r_desc     <= 1'b0;
            r_k_last   <= C_LAST;
        end else begin
            if (w_in_fire) begin
                // Frame options are captured with the first sample only.
                if (r_load_cnt == '0) begin
                    r_desc   <= desc_i;
                    r_k_last <= w_k_last;
                end
                r_load_cnt <= (r_load_cnt == C_LAST) ? '0 : r_load_cnt + 1'b1;
            end
            if (r_state == ST_SORT) begin
                r_phase <= (r_phase == C_LAST) ? '0 : r_phase + 1'b1;
            end
            if (w_out_fire) begin
                r_rd_ptr <= (r_rd_ptr == r_k_last) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem[r_load_cnt] <= '{value: NETWORK_WIDTH'(in_data),
                                   index: INDEX_WIDTH'(r_load_cnt)};
        end else if (r_state == ST_SORT) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_mem[i] <= r_phase[0] ? w_odd[i] : w_even[i];
            end
        end
    end

    for (genvar k = 0; k < N_ENTRIES / 2; k++) begin : g_even
        sort_cmp_exchange u_cx (
            .i_a    (r_mem[2*k]),
            .i_b    (r_mem[2*k+1]),
            .i_desc (r_desc),
            .o_a    (w_even[2*k]),
            .o_b    (w_even[2*k+1])
        );
    end

    // Odd phases leave the two end slots untouched.
    assign w_odd[0]           = r_mem[0];
    assign w_odd[N_ENTRIES-1] = r_mem[N_ENTRIES-1];
    for (genvar k = 0; k < N_ENTRIES / 2 - 1; k++) begin : g_odd
        sort_cmp_exchange u_cx (
            .i_a    (r_mem[2*k+1]),
            .i_b    (r_mem[2*k+2]),
            .i_desc (r_desc),
            .o_a    (w_odd[2*k+1]),
            .o_b    (w_odd[2*k+2])
        );
    end

    assign out_data  = (r_state == ST_DRAIN) ? r_mem[r_rd_ptr].value[DATA_W-1:0] : '0;
    assign out_index = (r_state == ST_DRAIN) ? r_mem[r_rd_ptr].index[IDX_W-1:0]  : '0;
    assign out_last  = (r_state == ST_DRAIN) && (r_rd_ptr == r_k_last);

endmodule
`default_nettype wire
